// File: rtl/branch_predict_unit.sv
// Branch resolution, bimodal prediction and ALU-op decode for the MIPS pipeline.
// Predicts at IF from a 2-bit counter table; resolves beq/bne/j and steers the PC mux.
module branch_predict_unit #(
    parameter int unsigned BHT_ENTRIES  = 16,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLUSH_SHADOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic             if_is_branch,
    input  logic [31:0]      if_pc,
    output logic             if_redirect,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Func,
    input  logic             Zero,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             ifflush,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic [1:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             is_branch, active, taken, br_upd, mispred;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

    // Lookup reads the registered table; a same-cycle update is not bypassed.
    assign if_redirect = rst_n & if_valid & if_is_branch & bht_q[if_idx][1];

    always_comb begin
        ALUOp = 3'b000;
        unique case (Opcode)
            OpRtype: begin
                unique case (Func)
                    6'b100010: ALUOp = 3'b001;
                    6'b100100: ALUOp = 3'b010;
                    6'b100101: ALUOp = 3'b011;
                    6'b101010: ALUOp = 3'b100;
                    default:   ALUOp = 3'b000;
                endcase
            end
            OpAndi:  ALUOp = 3'b010;
            OpOri:   ALUOp = 3'b011;
            OpSlti:  ALUOp = 3'b100;
            default: ALUOp = 3'b000;
        endcase
    end

    assign is_branch = (Opcode == OpBeq) || (Opcode == OpBne);
    assign active    = rst_n & ex_valid & (shadow_q == 2'd0);

    always_comb begin
        PCSrc   = 2'b00;
        ifflush = 1'b0;
        br_upd  = 1'b0;
        mispred = 1'b0;
        taken   = (Opcode == OpBeq) ? Zero : ~Zero;
        if (active) begin
            if (Opcode == OpJ) begin
                PCSrc   = 2'b10;
                ifflush = 1'b1;
            end else if (is_branch) begin
                br_upd = 1'b1;
                if (taken && !ex_pred_taken) begin
                    PCSrc   = 2'b01;
                    ifflush = 1'b1;
                    mispred = 1'b1;
                end else if (!taken && ex_pred_taken) begin
                    // Predicted taken but falls through: refetch the instruction after the branch.
                    PCSrc   = 2'b11;
                    ifflush = 1'b1;
                    mispred = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bht_d = bht_q;
        if (br_upd) begin
            if (taken && bht_q[ex_idx] != 2'b11) begin
                bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
            end else if (!taken && bht_q[ex_idx] != 2'b00) begin
                bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
            end
        end

        if (ifflush) begin
            shadow_d = 2'(FLUSH_SHADOW);
        end else if (shadow_q != 2'd0) begin
            shadow_d = shadow_q - 2'd1;
        end else begin
            shadow_d = shadow_q;
        end

        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (perf_clr) begin
            br_cnt_d  = '0;
            mis_cnt_d = '0;
        end else begin
            if (br_upd && br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + 1'b1;
            end
            if (mispred && mis_cnt_q != '1) begin
                mis_cnt_d = mis_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            shadow_q  <= 2'd0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            bht_q     <= bht_d;
            shadow_q  <= shadow_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed plus randomized bench for branch_predict_unit against a behavioural model
// of the prediction table, shadow window and saturating counters.
module tb_branch_predict_unit;
    localparam int ENTRIES = 16;
    localparam int CW      = 4;
    localparam int SHADOW  = 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_valid, if_is_branch;
    logic [31:0]   if_pc;
    logic          if_redirect;
    logic          ex_valid, ex_pred_taken, Zero, perf_clr;
    logic [31:0]   ex_pc;
    logic [5:0]    Opcode, Func;
    logic [2:0]    ALUOp;
    logic [1:0]    PCSrc;
    logic          ifflush;
    logic [CW-1:0] br_count, mispred_count;

    int checks   = 0;
    int failures = 0;

    // Reference state: per-entry counter value 0..3, shadow cycles left, event counts.
    int m_bht [ENTRIES];
    int m_shadow, m_br, m_mis;

    branch_predict_unit #(
        .BHT_ENTRIES (ENTRIES),
        .CNT_W       (CW),
        .FLUSH_SHADOW(SHADOW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_is_branch (if_is_branch),
        .if_pc        (if_pc),
        .if_redirect  (if_redirect),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_pred_taken(ex_pred_taken),
        .Opcode       (Opcode),
        .Func         (Func),
        .Zero         (Zero),
        .ALUOp        (ALUOp),
        .PCSrc        (PCSrc),
        .ifflush      (ifflush),
        .perf_clr     (perf_clr),
        .br_count     (br_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_alu(input int op, input int fn);
        if (op == 0) begin
            if (fn == 'h22) return 1;
            if (fn == 'h24) return 2;
            if (fn == 'h25) return 3;
            if (fn == 'h2a) return 4;
            return 0;
        end
        if (op == 'h0c) return 2;
        if (op == 'h0d) return 3;
        if (op == 'h0a) return 4;
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
        m_shadow = 0;
        m_br     = 0;
        m_mis    = 0;
    endtask

    task automatic drive(input bit ifv, input bit ifb, input logic [31:0] ipc, input bit exv,
                         input logic [31:0] epc, input bit pred, input int op, input int fn,
                         input bit z, input bit clr);
        if_valid      = ifv;
        if_is_branch  = ifb;
        if_pc         = ipc;
        ex_valid      = exv;
        ex_pc         = epc;
        ex_pred_taken = pred;
        Opcode        = 6'(op);
        Func          = 6'(fn);
        Zero          = z;
        perf_clr      = clr;
    endtask

    // Check one cycle against the model (inputs applied at the preceding negedge), then clock it.
    task automatic step();
        int  e_src, e_redir, idx;
        bit  act, isbr, tk, e_flush, mis;
        #1;
        e_redir = (if_valid && if_is_branch && m_bht[(if_pc >> 2) % ENTRIES] >= 2) ? 1 : 0;
        act     = ex_valid && (m_shadow == 0);
        isbr    = (Opcode == 6'd4) || (Opcode == 6'd5);
        tk      = (Opcode == 6'd4) ? Zero : !Zero;
        e_src   = 0;
        mis     = 0;
        if (act && Opcode == 6'd2) e_src = 2;
        else if (act && isbr && tk && !ex_pred_taken) begin e_src = 1; mis = 1; end
        else if (act && isbr && !tk && ex_pred_taken) begin e_src = 3; mis = 1; end
        e_flush = (e_src != 0);
        chk("if_redirect", 32'(if_redirect), 32'(e_redir));
        chk("PCSrc", 32'(PCSrc), 32'(e_src));
        chk("ifflush", 32'(ifflush), 32'(e_flush));
        chk("ALUOp", 32'(ALUOp), 32'(m_alu(int'(Opcode), int'(Func))));
        chk("br_count", 32'(br_count), 32'(m_br));
        chk("mispred_count", 32'(mispred_count), 32'(m_mis));
        idx = (ex_pc >> 2) % ENTRIES;
        @(posedge clk);
        if (act && isbr) begin
            m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                            : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
        end
        if (perf_clr) begin
            m_br  = 0;
            m_mis = 0;
        end else begin
            if (act && isbr && m_br < CNT_MAX) m_br++;
            if (mis && m_mis < CNT_MAX) m_mis++;
        end
        m_shadow = e_flush ? SHADOW : ((m_shadow > 0) ? m_shadow - 1 : 0);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        logic [17:0] sweep [14];
        int ops [10];

        // Reset holds resolve outputs low even with an active taken beq.
        rst_n = 1'b0;
        drive(1, 1, 32'h40, 1, 32'h40, 0, 4, 0, 1, 0);
        #12;
        chk("rst_PCSrc", 32'(PCSrc), 32'd0);
        chk("rst_ifflush", 32'(ifflush), 32'd0);
        chk("rst_redirect", 32'(if_redirect), 32'd0);
        Opcode = 6'b001101;
        #1;
        chk("rst_ALUOp", 32'(ALUOp), 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();

        // Fresh table predicts not-taken everywhere.
        for (int i = 0; i < ENTRIES; i++) begin
            drive(1, 1, 32'(i * 4 + 32'h100), 0, 0, 0, 0, 0, 0, 0);
            step();
        end

        // Training at 0x40.
        drive(0, 0, 0, 1, 32'h40, 0, 4, 0, 1, 0);
        #1;
        chk("train_PCSrc", 32'(PCSrc), 32'd1);
        step();
        idle();
        drive(1, 1, 32'h40, 1, 32'h40, 1, 4, 0, 1, 0);
        #1;
        chk("trained_redirect", 32'(if_redirect), 32'd1);
        chk("correct_PCSrc", 32'(PCSrc), 32'd0);
        step();
        chk("br_count_2", 32'(br_count), 32'd2);
        chk("mispred_1", 32'(mispred_count), 32'd1);

        // Entry now 11; bne with Zero=1 is not taken but predicted taken.
        drive(1, 1, 32'h40, 1, 32'h40, 1, 5, 0, 1, 0);
        #1;
        chk("reverse_PCSrc", 32'(PCSrc), 32'd3);
        step();
        idle();
        drive(1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Shadow: j, then ignored beq, then honoured beq.
        drive(0, 0, 0, 1, 32'h200, 0, 2, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 32'h44, 0, 4, 0, 1, 0);
        #1;
        chk("shadow_PCSrc", 32'(PCSrc), 32'd0);
        step();
        drive(0, 0, 0, 1, 32'h44, 0, 4, 0, 1, 0);
        #1;
        chk("post_shadow_PCSrc", 32'(PCSrc), 32'd1);
        step();
        idle();

        // 20 mispredicts saturate both counters.
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, 32'h48, 0, 4, 0, 1, 0);
            step();
            idle();
        end
        chk("mispred_sat", 32'(mispred_count), 32'(CNT_MAX));

        drive(0, 0, 0, 1, 32'h48, 0, 4, 0, 1, 1);
        step();
        chk("clr_br", 32'(br_count), 32'd0);
        chk("clr_mis", 32'(mispred_count), 32'd0);
        idle();

        // Five correctly predicted taken resolves pin 0x80 at the top; two not-taken then drop it.
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 32'h80, 1, 4, 0, 1, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 32'h80, 1, 32'h80, 0, 4, 0, 0, 0);
            step();
        end
        drive(1, 1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
        step();

        // ALUOp decode sweep: {opcode, funct, code}.
        sweep = '{{6'h00, 6'h22, 3'd1, 3'd0}, {6'h00, 6'h24, 3'd2, 3'd0},
                  {6'h00, 6'h25, 3'd3, 3'd0}, {6'h00, 6'h2a, 3'd4, 3'd0},
                  {6'h00, 6'h20, 3'd0, 3'd0}, {6'h00, 6'h3f, 3'd0, 3'd0},
                  {6'h0c, 6'h22, 3'd2, 3'd0}, {6'h0c, 6'h00, 3'd2, 3'd1},
                  {6'h0d, 6'h00, 3'd3, 3'd0}, {6'h0a, 6'h2a, 3'd4, 3'd0},
                  {6'h04, 6'h22, 3'd0, 3'd0}, {6'h23, 6'h22, 3'd0, 3'd0},
                  {6'h02, 6'h25, 3'd0, 3'd0}, {6'h0c, 6'h24, 3'd2, 3'd1}};
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 0, 0, 0, 0, int'(sweep[i][17:12]), int'(sweep[i][11:6]),
                  sweep[i][0], 0);
            #1;
            chk("alu_sweep", 32'(ALUOp), 32'(sweep[i][5:3]));
            Zero = ~Zero;
            #1;
            chk("alu_zero_toggle", 32'(ALUOp), 32'(sweep[i][5:3]));
            step();
        end

        // Reset during the shadow window: first resolve after release is honoured.
        drive(0, 0, 0, 1, 32'h300, 0, 2, 0, 0, 0);
        step();
        rst_n = 1'b0;
        #2;
        chk("midrst_ifflush", 32'(ifflush), 32'd0);
        rst_n = 1'b1;
        m_reset();
        drive(0, 0, 0, 1, 32'h4c, 0, 4, 0, 1, 0);
        #1;
        chk("midrst_PCSrc", 32'(PCSrc), 32'd1);
        step();

        // Randomized traffic over a handful of aliased indices.
        ops = '{0, 2, 4, 5, 4, 5, 12, 13, 10, 35};
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom), 1'($urandom_range(0, 3) != 0),
                  ($urandom & 32'hffff_ff00) | 32'($urandom_range(0, 31) << 2),
                  1'($urandom_range(0, 4) != 0),
                  ($urandom & 32'hffff_ff00) | 32'($urandom_range(0, 31) << 2),
                  1'($urandom), (n % 7 == 3) ? int'($urandom_range(0, 63))
                                             : ops[$urandom_range(0, 9)],
                  int'($urandom_range(0, 63)), 1'($urandom),
                  1'($urandom_range(0, 40) == 0));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
